// File: rtl/elem_stream_seq.sv
// elem_stream_seq: block-buffered elementwise-op sequencer.
// Streams num_words packed words from memories A/B through an external
// pipelined FP lane bundle in blocks of up to BURST words, and writes the
// results to the Res memory. A job is started with start and reported with
// a one-cycle done pulse.
// Optional feature: define ELEM_SEQ_PERF_EN to add the perf_cycles output,
// a saturating count of busy cycles for the most recent job.

module elem_stream_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int BANDWIDTH  = 8,
  parameter int BURST      = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16,
  parameter int LAT_WIDTH  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            num_words,
  input  logic [ADDR_WIDTH-1:0]           base_a,
  input  logic [ADDR_WIDTH-1:0]           base_b,
  input  logic [ADDR_WIDTH-1:0]           base_res,
  input  logic                            use_b,
  input  logic [DATA_WIDTH-1:0]           scalar,
  input  logic [LAT_WIDTH-1:0]            op_latency,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_a_en,
  output logic                            rd_b_en,
  output logic [ADDR_WIDTH-1:0]           rd_a_addr,
  output logic [ADDR_WIDTH-1:0]           rd_b_addr,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] rd_a_data,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] rd_b_data,
  output logic                            op_valid,
  output logic [BANDWIDTH*DATA_WIDTH-1:0] op_a,
  output logic [BANDWIDTH*DATA_WIDTH-1:0] op_b,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] res_data,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [BANDWIDTH*DATA_WIDTH-1:0] wr_data
`ifdef ELEM_SEQ_PERF_EN
  ,
  output logic [31:0]                     perf_cycles
`endif
);

  localparam int WORD_W = BANDWIDTH * DATA_WIDTH;
  // Wide enough to hold a block length of BURST; buffers are sized to the
  // full index range so every index is exactly in range.
  localparam int BL_W   = $clog2(BURST + 1);
  localparam int NBUF   = 1 << BL_W;
  localparam int MAXLAT = (1 << LAT_WIDTH) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_READ_LAST, S_COMPUTE, S_DRAIN, S_WRITE, S_FIN
  } state_t;

  state_t r_state, w_nextState;

  logic [CNT_WIDTH-1:0]  r_numWords;
  logic [ADDR_WIDTH-1:0] r_baseA, r_baseB, r_baseRes;
  logic                  r_useB;
  logic [DATA_WIDTH-1:0] r_scalar;
  logic [LAT_WIDTH-1:0]  r_lat;

  logic [CNT_WIDTH-1:0]  r_blockPtr;
  logic [BL_W-1:0]       r_k;
  logic [BL_W-1:0]       r_resIdx;
  logic                  r_capValid;
  logic [BL_W-1:0]       r_capIdx;
  logic [MAXLAT-1:0]     r_vline;

  logic [WORD_W-1:0]     r_bufA [0:NBUF-1];
  logic [WORD_W-1:0]     r_bufB [0:NBUF-1];
  logic [WORD_W-1:0]     r_bufR [0:NBUF-1];

  logic [CNT_WIDTH-1:0]  w_remain;
  logic [BL_W-1:0]       w_blkLen;
  logic                  w_lastK;
  logic                  w_lastRes;
  logic [CNT_WIDTH-1:0]  w_nextPtr;
  logic [ADDR_WIDTH-1:0] w_wordOff;
  logic [LAT_WIDTH-1:0]  w_latIdx;
  logic                  w_resValid;
  logic [WORD_W-1:0]     w_scalarWord;

  // Block geometry: the current block is BURST words, or whatever is left.
  assign w_remain     = r_numWords - r_blockPtr;
  assign w_blkLen     = (w_remain >= CNT_WIDTH'(BURST)) ? BL_W'(BURST) : w_remain[BL_W-1:0];
  assign w_lastK      = (r_k == w_blkLen - BL_W'(1));
  assign w_lastRes    = (r_resIdx == w_blkLen - BL_W'(1));
  assign w_nextPtr    = r_blockPtr + CNT_WIDTH'(w_blkLen);
  assign w_wordOff    = r_blockPtr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(r_k);
  assign w_latIdx     = r_lat - LAT_WIDTH'(1);
  assign w_resValid   = r_vline[w_latIdx];
  assign w_scalarWord = {BANDWIDTH{r_scalar}};

  // State register; reset aborts any job immediately.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state and output decode; every output is zero outside its state.
  always_comb begin
    w_nextState = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FIN);
    rd_a_en     = 1'b0;
    rd_b_en     = 1'b0;
    rd_a_addr   = '0;
    rd_b_addr   = '0;
    op_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_nextState = (num_words == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        rd_a_en   = 1'b1;
        rd_a_addr = r_baseA + w_wordOff;
        if (r_useB) begin
          rd_b_en   = 1'b1;
          rd_b_addr = r_baseB + w_wordOff;
        end
        if (w_lastK) w_nextState = S_READ_LAST;
      end
      S_READ_LAST: w_nextState = S_COMPUTE;
      S_COMPUTE: begin
        op_valid = 1'b1;
        op_a     = r_bufA[r_k];
        op_b     = r_useB ? r_bufB[r_k] : w_scalarWord;
        if (w_lastK) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_resValid && w_lastRes) w_nextState = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = r_baseRes + w_wordOff;
        wr_data = r_bufR[r_k];
        if (w_lastK) w_nextState = (w_nextPtr < r_numWords) ? S_READ : S_FIN;
      end
      S_FIN: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Job parameters are latched on an accepted start; the word index walks
  // each block during read, compute and write, and the block pointer
  // advances once the block has been written back.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_numWords <= '0;
      r_baseA    <= '0;
      r_baseB    <= '0;
      r_baseRes  <= '0;
      r_useB     <= 1'b0;
      r_scalar   <= '0;
      r_lat      <= LAT_WIDTH'(1);
      r_blockPtr <= '0;
      r_k        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_k <= '0;
          if (start) begin
            r_numWords <= num_words;
            r_baseA    <= base_a;
            r_baseB    <= base_b;
            r_baseRes  <= base_res;
            r_useB     <= use_b;
            r_scalar   <= scalar;
            r_lat      <= (op_latency == '0) ? LAT_WIDTH'(1) : op_latency;
            r_blockPtr <= '0;
          end
        end
        S_READ, S_COMPUTE: r_k <= w_lastK ? '0 : r_k + BL_W'(1);
        S_WRITE: begin
          if (w_lastK) begin
            r_k        <= '0;
            r_blockPtr <= w_nextPtr;
          end else begin
            r_k <= r_k + BL_W'(1);
          end
        end
        default: r_k <= '0;
      endcase
    end
  end

  // Read data arrives one cycle after its strobe; remember which slot it
  // belongs to and store it on the following edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_capValid <= 1'b0;
      r_capIdx   <= '0;
      for (int i = 0; i < NBUF; i++) begin
        r_bufA[i] <= '0;
        r_bufB[i] <= '0;
      end
    end else begin
      r_capValid <= (r_state == S_READ);
      r_capIdx   <= r_k;
      if (r_capValid) begin
        r_bufA[r_capIdx] <= rd_a_data;
        r_bufB[r_capIdx] <= rd_b_data;
      end
    end
  end

  // A valid shift line mirrors the datapath pipeline; the tap chosen by the
  // latched latency marks the cycle each result is present on res_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vline  <= '0;
      r_resIdx <= '0;
      for (int i = 0; i < NBUF; i++) r_bufR[i] <= '0;
    end else begin
      r_vline <= {r_vline[MAXLAT-2:0], op_valid};
      if (r_state == S_READ_LAST) begin
        r_resIdx <= '0;
      end else if (w_resValid) begin
        r_bufR[r_resIdx] <= res_data;
        r_resIdx         <= r_resIdx + BL_W'(1);
      end
    end
  end

`ifdef ELEM_SEQ_PERF_EN
  logic [31:0] r_perfCycles;

  // Busy-cycle counter: cleared on an accepted start, saturating, and left
  // holding its value once the job has finished.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perfCycles <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_perfCycles <= '0;
    end else if (r_state != S_IDLE && r_perfCycles != '1) begin
      r_perfCycles <= r_perfCycles + 32'd1;
    end
  end

  assign perf_cycles = r_perfCycles;
`endif

endmodule

// File: tb/tb_elem_stream_seq.sv
// Testbench for elem_stream_seq: table of directed jobs, randomized jobs and
// a hand-written reset-abort sequence, checked against a job-level model of
// the expected read/write traces and completion time.

module tb_elem_stream_seq;

  localparam int DW     = 32;
  localparam int BW     = 8;
  localparam int BURST  = 4;
  localparam int AW     = 11;
  localparam int CW     = 16;
  localparam int LW     = 4;
  localparam int WORD_W = BW * DW;
  localparam int MEMSZ  = 1 << AW;

  logic              clock = 1'b0;
  logic              reset, start, use_b;
  logic [CW-1:0]     num_words;
  logic [AW-1:0]     base_a, base_b, base_res;
  logic [DW-1:0]     scalar;
  logic [LW-1:0]     op_latency;
  logic              busy, done, rd_a_en, rd_b_en, op_valid, wr_en;
  logic [AW-1:0]     rd_a_addr, rd_b_addr, wr_addr;
  logic [WORD_W-1:0] rd_a_data, rd_b_data, op_a, op_b, res_data, wr_data;
`ifdef ELEM_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  elem_stream_seq #(
    .DATA_WIDTH(DW), .BANDWIDTH(BW), .BURST(BURST),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .LAT_WIDTH(LW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words),
    .base_a(base_a), .base_b(base_b), .base_res(base_res), .use_b(use_b),
    .scalar(scalar), .op_latency(op_latency), .busy(busy), .done(done),
    .rd_a_en(rd_a_en), .rd_b_en(rd_b_en), .rd_a_addr(rd_a_addr),
    .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .res_data(res_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef ELEM_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          numWords;
    int          baseA;
    int          baseB;
    int          baseRes;
    bit          useB;
    logic [31:0] scalar;
    int          lat;
    bit          mulMode;
    int          expDone;
    bit          restart;
  } vecT;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [WORD_W-1:0] memA [0:MEMSZ-1];
  logic [WORD_W-1:0] memB [0:MEMSZ-1];
  logic [WORD_W-1:0] histA [0:15];
  logic [WORD_W-1:0] histB [0:15];
  int dpLat   = 1;
  bit mulMode = 1'b0;

  logic [AW-1:0]     rdAQ[$];
  logic [AW-1:0]     rdBQ[$];
  logic [AW-1:0]     wrAQ[$];
  logic [WORD_W-1:0] wrDQ[$];

  // Memories with one cycle of read latency.
  always @(posedge clock) begin
    if (rd_a_en) rd_a_data <= memA[rd_a_addr];
    if (rd_b_en) rd_b_data <= memB[rd_b_addr];
  end

  // External lane bundle: operands emerge as results dpLat cycles later.
  always @(posedge clock) begin
    histA[0] <= op_a;
    histB[0] <= op_b;
    for (int i = 1; i < 16; i++) begin
      histA[i] <= histA[i-1];
      histB[i] <= histB[i-1];
    end
  end

  function automatic logic [WORD_W-1:0] dpFunc(input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b,
                                                input bit mul);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int l = 0; l < BW; l++) begin
      logic [31:0] la, lb, lr;
      la = a[l*DW +: DW];
      lb = b[l*DW +: DW];
      if (mul) lr = {la[31] ^ lb[31], la[30:23] + lb[30:23] - 8'd127, la[22:0]};
      else     lr = la + lb;
      r[l*DW +: DW] = lr;
    end
    return r;
  endfunction

  always_comb res_data = dpFunc(histA[dpLat-1], histB[dpLat-1], mulMode);

  // Trace every strobe the DUT issues.
  always @(posedge clock) begin
    if (rd_a_en) rdAQ.push_back(rd_a_addr);
    if (rd_b_en) rdBQ.push_back(rd_b_addr);
    if (wr_en) begin
      wrAQ.push_back(wr_addr);
      wrDQ.push_back(wr_data);
    end
  end

  function automatic logic [WORD_W-1:0] randWord();
    logic [WORD_W-1:0] w;
    for (int l = 0; l < BW; l++)
      w[l*DW +: DW] = {1'($urandom), 8'($urandom_range(1, 200)), 23'($urandom)};
    return w;
  endfunction

  // Expected result word i of a job: A+B (or A+scalar), or A doubled for
  // the multiply-by-2.0 jobs.
  function automatic logic [WORD_W-1:0] expWord(input vecT v, input int i);
    logic [WORD_W-1:0] a, b, r;
    a = memA[(v.baseA + i) % MEMSZ];
    b = v.useB ? memB[(v.baseB + i) % MEMSZ] : {BW{v.scalar}};
    for (int l = 0; l < BW; l++) begin
      logic [31:0] la, lb;
      la = a[l*DW +: DW];
      lb = b[l*DW +: DW];
      if (v.mulMode) r[l*DW +: DW] = {la[31], la[30:23] + 8'd1, la[22:0]};
      else           r[l*DW +: DW] = la + lb;
    end
    return r;
  endfunction

  // Completion cycle, counting the start cycle as cycle 1: one accept
  // cycle, then per block (len+1) read + (len+L) compute/drain + len write,
  // then the done cycle.
  function automatic int expectedDone(input int num, input int lat);
    int c, b, latEff;
    latEff = (lat == 0) ? 1 : lat;
    c = 1;
    for (int p = 0; p < num; p += BURST) begin
      b = (num - p < BURST) ? num - p : BURST;
      c += (b + 1) + (b + latEff) + b;
    end
    return c + 1;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checksTotal++;
    if (act == exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkWord(input string name, input logic [WORD_W-1:0] act,
                           input logic [WORD_W-1:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic clearTraces();
    rdAQ.delete();
    rdBQ.delete();
    wrAQ.delete();
    wrDQ.delete();
  endtask

  // Run one job: start for one cycle, then scramble the inputs to show the
  // latched copies are used; optionally re-assert start during WRITE.
  task automatic applyStimulus(input vecT v, input int idx);
    int cyc, doneCyc, doneCnt, busyCnt, postDone, restartPhase;
    longint perfAfterDone;
    clearTraces();
    dpLat   = (v.lat == 0) ? 1 : v.lat;
    mulMode = v.mulMode;
    @(negedge clock);
    num_words  = CW'(v.numWords);
    base_a     = AW'(v.baseA);
    base_b     = AW'(v.baseB);
    base_res   = AW'(v.baseRes);
    use_b      = v.useB;
    scalar     = v.scalar;
    op_latency = LW'(v.lat);
    start      = 1'b1;
    cyc = 1; doneCyc = -1; doneCnt = 0; busyCnt = 0; postDone = 0;
    restartPhase = 0; perfAfterDone = -1;
    for (int t = 0; t < 2000 && postDone < 3; t++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 2) begin
        start      = 1'b0;
        num_words  = CW'($urandom_range(1, 20));
        base_a     = AW'($urandom);
        base_b     = AW'($urandom);
        base_res   = AW'($urandom);
        use_b      = ~v.useB;
        scalar     = $urandom;
        op_latency = LW'($urandom);
      end
      if (restartPhase == 1) begin
        start = 1'b0;
        restartPhase = 2;
      end
      if (v.restart && restartPhase == 0 && wr_en) begin
        start = 1'b1;
        num_words = CW'(3);
        restartPhase = 1;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (doneCyc >= 0 && cyc == doneCyc + 1) begin
        checkOutput($sformatf("busyAfterDone v%0d", idx), busy, 0);
`ifdef ELEM_SEQ_PERF_EN
        perfAfterDone = perf_cycles;
`endif
      end
      if (doneCyc >= 0 && cyc > doneCyc) postDone++;
    end

    checkOutput($sformatf("doneCycle v%0d", idx), doneCyc, v.expDone);
    checkOutput($sformatf("donePulses v%0d", idx), doneCnt, 1);
    checkOutput($sformatf("rdACount v%0d", idx), rdAQ.size(), v.numWords);
    for (int i = 0; i < rdAQ.size() && i < v.numWords; i++)
      checkOutput($sformatf("rdAAddr[%0d] v%0d", i, idx), rdAQ[i], (v.baseA + i) % MEMSZ);
    checkOutput($sformatf("rdBCount v%0d", idx), rdBQ.size(), v.useB ? v.numWords : 0);
    for (int i = 0; i < rdBQ.size() && i < v.numWords; i++)
      checkOutput($sformatf("rdBAddr[%0d] v%0d", i, idx), rdBQ[i], (v.baseB + i) % MEMSZ);
    checkOutput($sformatf("wrCount v%0d", idx), wrAQ.size(), v.numWords);
    for (int i = 0; i < wrAQ.size() && i < v.numWords; i++) begin
      checkOutput($sformatf("wrAddr[%0d] v%0d", i, idx), wrAQ[i], (v.baseRes + i) % MEMSZ);
      checkWord($sformatf("wrData[%0d] v%0d", i, idx), wrDQ[i], expWord(v, i));
    end
`ifdef ELEM_SEQ_PERF_EN
    checkOutput($sformatf("perfBusy v%0d", idx), perf_cycles, busyCnt);
    checkOutput($sformatf("perfCycles v%0d", idx), perf_cycles, v.expDone - 1);
    checkOutput($sformatf("perfHold v%0d", idx), perf_cycles, perfAfterDone);
`endif
  endtask

  // Reset during COMPUTE: next cycle idle with all strobes low, and the
  // aborted job never reports done.
  task automatic resetMidJob();
    int found, doneSeen;
    clearTraces();
    dpLat = 7;
    mulMode = 1'b0;
    @(negedge clock);
    num_words = CW'(8); base_a = '0; base_b = AW'(12'h100); base_res = AW'(12'h200);
    use_b = 1'b1; op_latency = LW'(7); start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 100; t++) begin
      if (op_valid) begin
        found = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    checkOutput("reachCompute", found, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidStrobes", {rd_a_en, rd_b_en, wr_en, op_valid, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    clearTraces();
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("rstMidNoDone", doneSeen, 0);
    checkOutput("rstMidNoReads", rdAQ.size() + rdBQ.size(), 0);
    checkOutput("rstMidNoWrites", wrAQ.size(), 0);
  endtask

  vecT vecs[7];

  initial begin
    vecT r;
    reset = 1'b1; start = 1'b0; num_words = '0; base_a = '0; base_b = '0;
    base_res = '0; use_b = 1'b0; scalar = '0; op_latency = '0;
    for (int i = 0; i < MEMSZ; i++) begin
      memA[i] = randWord();
      memB[i] = randWord();
    end

    //          num  baseA  baseB  baseRes useB scalar        lat mul done restart
    vecs[0] = '{8,   'h000, 'h100, 'h200,  1,   32'h0,        7,  0,  42,  0};
    vecs[1] = '{6,   'h010, 'h110, 'h210,  1,   32'h0,        3,  0,  28,  0};
    vecs[2] = '{8,   'h020, 'h120, 'h220,  0,   32'h40000000, 5,  1,  38,  0};
    vecs[3] = '{0,   'h030, 'h130, 'h230,  1,   32'h0,        4,  0,  2,   0};
    vecs[4] = '{4,   'h040, 'h140, 'h7FE,  1,   32'h0,        1,  0,  16,  0};
    vecs[5] = '{3,   'h050, 'h150, 'h250,  1,   32'h0,        0,  0,  13,  0};
    vecs[6] = '{8,   'h060, 'h160, 'h260,  1,   32'h0,        2,  0,  32,  1};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstStrobes", {rd_a_en, rd_b_en, wr_en, op_valid}, 0);
    checkOutput("rstAddrs", {rd_a_addr, rd_b_addr, wr_addr}, 0);
    checkWord("rstWrData", wr_data, '0);
    checkWord("rstOpA", op_a, '0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    for (int i = 0; i < 6; i++) begin
      r.numWords = $urandom_range(1, 11);
      r.baseA    = $urandom_range(0, MEMSZ - 1);
      r.baseB    = $urandom_range(0, MEMSZ - 1);
      r.baseRes  = $urandom_range(0, MEMSZ - 1);
      r.useB     = 1'($urandom);
      r.scalar   = $urandom;
      r.lat      = $urandom_range(0, 15);
      r.mulMode  = 1'b0;
      r.restart  = 1'b0;
      r.expDone  = expectedDone(r.numWords, r.lat);
      applyStimulus(r, 100 + i);
    end

    resetMidJob();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
